// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with memory handshakes
// and a HI/LO busy counter that interlocks multiply/divide issue and mfhi/mflo/mthi/mtlo.
module mc_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        br_taken,
  output logic        imem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        regwrite,
  output logic [1:0]  regdst,
  output logic [1:0]  wb_sel,
  output logic        alusrc,
  output logic [1:0]  extop,
  output logic [3:0]  aluop,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [1:0]  mem_size,
  output logic        mem_sext,
  output logic        md_start,
  output logic [2:0]  md_op,
  output logic        md_busy,
  output logic        illegal,
  output logic [2:0]  state
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} st_e;
  typedef enum logic [3:0] {C_NOP, C_ALU, C_LOAD, C_STORE, C_BR, C_J, C_JAL, C_JR, C_JALR, C_MD, C_MT} cls_e;
  typedef struct packed {
    cls_e       cls;
    logic [3:0] aluop;
    logic       alusrc;
    logic [1:0] extop;
    logic [1:0] regdst;
    logic [1:0] wb_sel;
    logic [1:0] mem_size;
    logic       mem_sext;
    logic [2:0] md_op;
  } cw_t;

  st_e st, nxt;
  cw_t cw, d;
  logic ok, is_md, stall;
  logic [CNT_W-1:0] cnt;
  logic [5:0] op, fn;
  logic [4:0] rt, rd;
  logic unused_bits;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign rt = instr[20:16];
  assign rd = instr[15:11];
  assign unused_bits = ^{instr[25:21], instr[10:6]};
  assign state = st;
  assign md_busy = cnt != '0;
  assign stall = is_md && md_busy;

  always_comb begin
    d = '0;
    ok = 1'b1;
    is_md = 1'b0;
    case (op)
      6'h00: begin
        d.cls = C_ALU;
        d.regdst = 2'd1;
        case (fn)
          6'h00: begin d.aluop = 4'b1010; if (rd == 5'd0) d.cls = C_NOP; end
          6'h02: d.aluop = 4'b1011;
          6'h03: d.aluop = 4'b1001;
          6'h04: d.aluop = 4'b0111;
          6'h06: d.aluop = 4'b1000;
          6'h07: d.aluop = 4'b1100;
          6'h08: d.cls = C_JR;
          6'h09: begin d.cls = C_JALR; d.wb_sel = 2'd2; end
          6'h10, 6'h12: begin d.wb_sel = 2'd3; is_md = 1'b1; end
          6'h11, 6'h13: begin d.cls = C_MT; d.md_op = fn[1] ? 3'd5 : 3'd4; is_md = 1'b1; end
          6'h18, 6'h19, 6'h1a, 6'h1b: begin d.cls = C_MD; d.md_op = {1'b0, fn[1:0]}; is_md = 1'b1; end
          6'h20, 6'h21: d.aluop = 4'b0000;
          6'h22, 6'h23: d.aluop = 4'b0001;
          6'h24: d.aluop = 4'b0010;
          6'h25: d.aluop = 4'b0011;
          6'h26: d.aluop = 4'b0100;
          6'h27: d.aluop = 4'b0101;
          6'h2a: d.aluop = 4'b0110;
          6'h2b: d.aluop = 4'b1101;
          default: ok = 1'b0;
        endcase
      end
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07: begin
        d.cls = C_BR;
        d.aluop = 4'b0001;
        d.extop = 2'd1;
        ok = op != 6'h01 || rt == 5'd0 || rt == 5'd1;
      end
      6'h02: d.cls = C_J;
      6'h03: begin d.cls = C_JAL; d.regdst = 2'd2; d.wb_sel = 2'd2; end
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
        d.cls = C_ALU;
        d.alusrc = 1'b1;
        d.extop = !op[2] ? 2'd1 : op[1:0] == 2'b11 ? 2'd2 : 2'd0;
        d.aluop = op[2:0] == 3'd2 ? 4'b0110 : op[2:0] == 3'd3 ? 4'b1101 :
                  op[2:0] == 3'd4 ? 4'b0010 : op[2:0] == 3'd5 ? 4'b0011 :
                  op[2:0] == 3'd6 ? 4'b0100 : 4'b0000;
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b: begin
        d.cls = op[3] ? C_STORE : C_LOAD;
        d.alusrc = 1'b1;
        d.extop = 2'd1;
        d.wb_sel = op[3] ? 2'd0 : 2'd1;
        d.mem_size = op[1:0] == 2'b11 ? 2'd2 : {1'b0, op[0]};
        d.mem_sext = !op[3] && !op[2] && op[1:0] != 2'b11;
      end
      default: ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= FETCH;
      cw <= '0;
      cnt <= '0;
    end else begin
      st <= nxt;
      if (st == DECODE && !stall) cw <= ok ? d : '0;
      cnt <= (st == EXEC && cw.cls == C_MD) ? (cw.md_op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT)) :
             md_busy ? cnt - CNT_W'(1) : cnt;
    end
  end

  always_comb begin
    nxt = st;
    imem_req = 1'b0;
    ir_we = 1'b0;
    pc_we = 1'b0;
    pc_src = 2'd0;
    regwrite = 1'b0;
    regdst = 2'd0;
    wb_sel = 2'd0;
    alusrc = 1'b0;
    extop = 2'd0;
    aluop = 4'd0;
    dmem_req = 1'b0;
    dmem_we = 1'b0;
    mem_size = 2'd0;
    mem_sext = 1'b0;
    md_start = 1'b0;
    md_op = 3'd0;
    illegal = 1'b0;
    // ALU controls are held through MEM/WB so the address/result path stays stable
    if (st == EXEC || st == MEM || st == WB) begin
      aluop = cw.aluop;
      alusrc = cw.alusrc;
      extop = cw.extop;
    end
    case (st)
      FETCH: begin
        imem_req = 1'b1;
        ir_we = imem_ready;
        pc_we = imem_ready;
        nxt = imem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        illegal = !ok;
        nxt = stall ? DECODE : ok ? EXEC : FETCH;
      end
      EXEC: begin
        md_start = cw.cls == C_MD || cw.cls == C_MT;
        md_op = cw.md_op;
        pc_we = cw.cls == C_BR ? br_taken :
                cw.cls == C_J || cw.cls == C_JAL || cw.cls == C_JR || cw.cls == C_JALR;
        pc_src = cw.cls == C_BR ? 2'd1 : (cw.cls == C_J || cw.cls == C_JAL) ? 2'd2 :
                 (cw.cls == C_JR || cw.cls == C_JALR) ? 2'd3 : 2'd0;
        nxt = (cw.cls == C_LOAD || cw.cls == C_STORE) ? MEM :
              (cw.cls == C_ALU || cw.cls == C_JAL || cw.cls == C_JALR) ? WB : FETCH;
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we = cw.cls == C_STORE;
        mem_size = cw.mem_size;
        mem_sext = cw.mem_sext;
        nxt = !dmem_ready ? MEM : cw.cls == C_STORE ? FETCH : WB;
      end
      WB: begin
        regwrite = 1'b1;
        regdst = cw.regdst;
        wb_sel = cw.wb_sel;
        nxt = FETCH;
      end
      default: nxt = FETCH;
    endcase
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed tests for mc_ctrl; each task drives one scenario and checks a per-cycle
// trace of the outputs against hand-computed values.
module tb_mc_ctrl;
  logic clk, rst_n, imem_ready, dmem_ready, br_taken;
  logic [31:0] instr;
  logic imem_req, ir_we, pc_we, regwrite, alusrc, dmem_req, dmem_we, mem_sext, md_start, md_busy, illegal;
  logic [1:0] pc_src, regdst, wb_sel, extop, mem_size;
  logic [3:0] aluop;
  logic [2:0] md_op, state;
  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [2:0] st;
    logic ir_we;
    logic pc_we;
    logic [1:0] pc_src;
    logic rw;
    logic [1:0] regdst;
    logic [1:0] wb_sel;
    logic [3:0] aluop;
    logic [1:0] extop;
    logic alusrc;
    logic dreq;
    logic dwe;
    logic [1:0] msize;
    logic msext;
    logic mds;
    logic [2:0] mdop;
    logic busy;
    logic ill;
    logic ireq;
  } snap_t;
  snap_t cur;
  snap_t tr [100];

  mc_ctrl #(.MULT_LAT(5), .DIV_LAT(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .br_taken(br_taken), .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .regwrite(regwrite), .regdst(regdst), .wb_sel(wb_sel), .alusrc(alusrc), .extop(extop),
    .aluop(aluop), .dmem_req(dmem_req), .dmem_we(dmem_we), .mem_size(mem_size),
    .mem_sext(mem_sext), .md_start(md_start), .md_op(md_op), .md_busy(md_busy),
    .illegal(illegal), .state(state)
  );

  assign cur = {state, ir_we, pc_we, pc_src, regwrite, regdst, wb_sel, aluop, extop, alusrc,
                dmem_req, dmem_we, mem_size, mem_sext, md_start, md_op, md_busy, illegal, imem_req};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one instruction from FETCH back to FETCH, sampling 1ns after each falling edge.
  task automatic run(input logic [31:0] ins, input int iw, input int dw, input logic bt, output int n);
    int iwc, dwc;
    bit left;
    instr = ins;
    br_taken = bt;
    n = 0; iwc = 0; dwc = 0; left = 0;
    while (n < 100 && !(left && state == 3'd0)) begin
      imem_ready = state == 3'd0 && iwc >= iw;
      dmem_ready = state == 3'd3 && dwc >= dw;
      if (state == 3'd0) iwc++;
      if (state == 3'd3) dwc++;
      #1;
      tr[n] = cur;
      n++;
      @(negedge clk);
      if (state != 3'd0) left = 1;
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rst_imem_req got=%b exp=1", imem_req); end
    total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL rst_md_busy got=%b exp=0", md_busy); end
    total++; if ({ir_we, pc_we, regwrite, dmem_req, md_start, illegal} !== 6'b0) begin bad++; $display("FAIL rst_enables got=%b exp=000000", {ir_we, pc_we, regwrite, dmem_req, md_start, illegal}); end
    total++; if ({pc_src, regdst, wb_sel, aluop, extop} !== 12'b0) begin bad++; $display("FAIL rst_ctrl got=%h exp=0", {pc_src, regdst, wb_sel, aluop, extop}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu;
    int n, c;
    logic [2:0] es [4];
    es = '{3'd0, 3'd1, 3'd2, 3'd4};
    run(32'h00221821, 0, 0, 1'b0, n);
    total++; if (n !== 4) begin bad++; $display("FAIL alu_len got=%0d exp=4", n); end
    for (int i = 0; i < 4; i++) begin
      total++; if (tr[i].st !== es[i]) begin bad++; $display("FAIL alu_state[%0d] got=%0d exp=%0d", i, tr[i].st, es[i]); end
    end
    total++; if ({tr[0].ir_we, tr[0].pc_we, tr[0].pc_src} !== 4'b1100) begin bad++; $display("FAIL alu_fetch got=%b exp=1100", {tr[0].ir_we, tr[0].pc_we, tr[0].pc_src}); end
    total++; if ({tr[3].rw, tr[3].regdst, tr[3].wb_sel, tr[3].aluop} !== 9'b1_01_00_0000) begin bad++; $display("FAIL alu_wb got=%b exp=101000000", {tr[3].rw, tr[3].regdst, tr[3].wb_sel, tr[3].aluop}); end
    c = 0;
    for (int i = 0; i < n; i++) if (tr[i].rw) c++;
    total++; if (c !== 1) begin bad++; $display("FAIL alu_rw_count got=%0d exp=1", c); end
  endtask

  task automatic test_load;
    int n, c;
    run(32'h8C850008, 0, 3, 1'b0, n);
    total++; if (n !== 8) begin bad++; $display("FAIL lw_len got=%0d exp=8", n); end
    c = 0;
    for (int i = 0; i < n; i++) if (tr[i].dreq) c++;
    total++; if (c !== 4) begin bad++; $display("FAIL lw_dreq_cycles got=%0d exp=4", c); end
    total++; if ({tr[2].extop, tr[2].alusrc, tr[2].aluop} !== 7'b01_1_0000) begin bad++; $display("FAIL lw_exec got=%b exp=0110000", {tr[2].extop, tr[2].alusrc, tr[2].aluop}); end
    total++; if ({tr[4].msize, tr[4].msext, tr[4].dwe} !== 4'b1000) begin bad++; $display("FAIL lw_mem got=%b exp=1000", {tr[4].msize, tr[4].msext, tr[4].dwe}); end
    total++; if ({tr[7].st, tr[7].rw, tr[7].wb_sel, tr[7].regdst} !== 8'b100_1_01_00) begin bad++; $display("FAIL lw_wb got=%b exp=10010100", {tr[7].st, tr[7].rw, tr[7].wb_sel, tr[7].regdst}); end
  endtask

  task automatic test_store;
    int n, c;
    run(32'hAC850004, 2, 0, 1'b0, n);
    total++; if (n !== 6) begin bad++; $display("FAIL sw_len got=%0d exp=6", n); end
    total++; if ({tr[0].ireq, tr[0].ir_we, tr[2].ir_we} !== 3'b101) begin bad++; $display("FAIL sw_fetch_wait got=%b exp=101", {tr[0].ireq, tr[0].ir_we, tr[2].ir_we}); end
    total++; if ({tr[5].st, tr[5].dreq, tr[5].dwe, tr[5].msize} !== 7'b011_1_1_10) begin bad++; $display("FAIL sw_mem got=%b exp=0111110", {tr[5].st, tr[5].dreq, tr[5].dwe, tr[5].msize}); end
    c = 0;
    for (int i = 0; i < n; i++) if (tr[i].rw) c++;
    total++; if (c !== 0) begin bad++; $display("FAIL sw_rw_count got=%0d exp=0", c); end
  endtask

  task automatic test_branch;
    int n;
    run(32'h10220004, 0, 0, 1'b1, n);
    total++; if (n !== 3) begin bad++; $display("FAIL beq_t_len got=%0d exp=3", n); end
    total++; if ({tr[2].st, tr[2].pc_we, tr[2].pc_src} !== 6'b010_1_01) begin bad++; $display("FAIL beq_t_exec got=%b exp=010101", {tr[2].st, tr[2].pc_we, tr[2].pc_src}); end
    run(32'h10220004, 0, 0, 1'b0, n);
    total++; if (n !== 3) begin bad++; $display("FAIL beq_nt_len got=%0d exp=3", n); end
    total++; if (tr[2].pc_we !== 1'b0) begin bad++; $display("FAIL beq_nt_pc_we got=%b exp=0", tr[2].pc_we); end
  endtask

  task automatic test_jumps;
    int n;
    run(32'h08000010, 0, 0, 1'b0, n);
    total++; if (n !== 3) begin bad++; $display("FAIL j_len got=%0d exp=3", n); end
    run(32'h0C000010, 0, 0, 1'b0, n);
    total++; if (n !== 4) begin bad++; $display("FAIL jal_len got=%0d exp=4", n); end
    total++; if ({tr[2].pc_we, tr[2].pc_src} !== 3'b1_10) begin bad++; $display("FAIL jal_exec got=%b exp=110", {tr[2].pc_we, tr[2].pc_src}); end
    total++; if ({tr[3].rw, tr[3].regdst, tr[3].wb_sel} !== 5'b1_10_10) begin bad++; $display("FAIL jal_wb got=%b exp=11010", {tr[3].rw, tr[3].regdst, tr[3].wb_sel}); end
    run(32'h0020F809, 0, 0, 1'b0, n);
    total++; if (n !== 4) begin bad++; $display("FAIL jalr_len got=%0d exp=4", n); end
    total++; if ({tr[2].pc_we, tr[2].pc_src} !== 3'b1_11) begin bad++; $display("FAIL jalr_exec got=%b exp=111", {tr[2].pc_we, tr[2].pc_src}); end
    total++; if ({tr[3].rw, tr[3].regdst, tr[3].wb_sel} !== 5'b1_01_10) begin bad++; $display("FAIL jalr_wb got=%b exp=10110", {tr[3].rw, tr[3].regdst, tr[3].wb_sel}); end
  endtask

  task automatic test_md_interlock;
    int n;
    run(32'h00220018, 0, 0, 1'b0, n);
    total++; if ({n[3:0], tr[2].mds, tr[2].mdop} !== 8'b0011_1_000) begin bad++; $display("FAIL mult_issue got=%b exp=00111000", {n[3:0], tr[2].mds, tr[2].mdop}); end
    run(32'h00002010, 0, 0, 1'b0, n);
    total++; if (n !== 8) begin bad++; $display("FAIL mfhi_stall_len got=%0d exp=8", n); end
    total++; if ({tr[4].st, tr[4].busy, tr[5].busy} !== 5'b001_1_0) begin bad++; $display("FAIL mfhi_stall_edge got=%b exp=00110", {tr[4].st, tr[4].busy, tr[5].busy}); end
    total++; if ({tr[7].rw, tr[7].wb_sel, tr[7].regdst} !== 5'b1_11_01) begin bad++; $display("FAIL mfhi_wb got=%b exp=11101", {tr[7].rw, tr[7].wb_sel, tr[7].regdst}); end
    run(32'h00220018, 0, 0, 1'b0, n);
    run(32'h00221821, 0, 0, 1'b0, n);
    total++; if (n !== 4) begin bad++; $display("FAIL mult_nonblock_len got=%0d exp=4", n); end
    run(32'h00002010, 0, 0, 1'b0, n);
    total++; if (n !== 4) begin bad++; $display("FAIL mfhi_nostall_len got=%0d exp=4", n); end
  endtask

  task automatic test_back_to_back;
    int n;
    run(32'h0022001A, 0, 0, 1'b0, n);
    total++; if ({tr[2].mds, tr[2].mdop} !== 4'b1_010) begin bad++; $display("FAIL div_issue got=%b exp=1010", {tr[2].mds, tr[2].mdop}); end
    run(32'h00002012, 0, 0, 1'b0, n);
    total++; if (n !== 35) begin bad++; $display("FAIL mflo_stall_len got=%0d exp=35", n); end
    total++; if ({tr[0].busy, tr[31].st, tr[31].busy, tr[32].busy} !== 6'b1_001_1_0) begin bad++; $display("FAIL mflo_busy got=%b exp=100110", {tr[0].busy, tr[31].st, tr[31].busy, tr[32].busy}); end
    total++; if ({tr[34].rw, tr[34].wb_sel} !== 3'b1_11) begin bad++; $display("FAIL mflo_wb got=%b exp=111", {tr[34].rw, tr[34].wb_sel}); end
  endtask

  task automatic test_illegal;
    int n, c, r;
    run(32'hFC000000, 0, 0, 1'b0, n);
    total++; if (n !== 2) begin bad++; $display("FAIL ill_len got=%0d exp=2", n); end
    c = 0; r = 0;
    for (int i = 0; i < n; i++) begin
      if (tr[i].ill) c++;
      if (tr[i].rw || tr[i].dreq || (tr[i].pc_we && tr[i].st != 3'd0)) r++;
    end
    total++; if ({c[3:0], tr[1].ill} !== 5'b0001_1) begin bad++; $display("FAIL ill_pulse got=%b exp=00011", {c[3:0], tr[1].ill}); end
    total++; if (r !== 0) begin bad++; $display("FAIL ill_side_effects got=%0d exp=0", r); end
  endtask

  task automatic test_reset_mid;
    int n;
    run(32'h0022001A, 0, 0, 1'b0, n);
    instr = 32'h8C850008;
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    total++; if ({state, dmem_req, md_busy} !== 5'b011_1_1) begin bad++; $display("FAIL mid_pre got=%b exp=01111", {state, dmem_req, md_busy}); end
    #1 rst_n = 1'b0;
    #1;
    total++; if ({state, dmem_req, imem_req, md_busy} !== 6'b000_0_1_0) begin bad++; $display("FAIL mid_async got=%b exp=000010", {state, dmem_req, imem_req, md_busy}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    total++; if ({state, imem_req, md_busy, dmem_req} !== 6'b000_1_0_0) begin bad++; $display("FAIL mid_release got=%b exp=000100", {state, imem_req, md_busy, dmem_req}); end
  endtask

  initial begin
    rst_n = 1'b0;
    instr = '0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    br_taken = 1'b0;
    test_reset;
    test_alu;
    test_load;
    test_store;
    test_branch;
    test_jumps;
    test_md_interlock;
    test_back_to_back;
    test_illegal;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle control unit for the MIPS core. It replaces purely combinational decode with a sequential FSM that steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It handshakes with variable-latency instruction and data memories and issues to the multiply/divide unit, interlocking mfhi/mflo/mthi/mtlo and new mult/div issues against a latency counter. It drives the existing datapath muxes and enables.

Parameters:
MULT_LAT, 5, cycles mult/multu keeps HI/LO busy after issue (1..2^CNT_W-1)
DIV_LAT, 32, cycles div/divu keeps HI/LO busy after issue (1..2^CNT_W-1)
CNT_W, 6, width of the md busy counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr  in  32  IR contents from the datapath, valid from the cycle after ir_we
imem_ready  in  1  instruction memory data valid this cycle
dmem_ready  in  1  data memory access complete this cycle
br_taken  in  1  datapath branch condition for the decoded branch
imem_req  out  1  instruction fetch request
ir_we  out  1  load IR
pc_we  out  1  PC write enable
pc_src  out  2  0 pc+4, 1 branch target, 2 jump target, 3 rs (jr/jalr)
regwrite  out  1  register file write
regdst  out  2  0 rt, 1 rd, 2 r31
wb_sel  out  2  0 alu, 1 mem, 2 pc+4 link, 3 hi/lo
alusrc  out  1  1 = immediate operand
extop  out  2  0 zero-extend, 1 sign-extend, 2 lui shift
aluop  out  4  add 0000, sub 0001, and 0010, or 0011, xor 0100, nor 0101, slt 0110, sllv 0111, srlv 1000, sra 1001, sll 1010, srl 1011, srav 1100, sltu 1101
dmem_req  out  1  data memory request
dmem_we  out  1  store
mem_size  out  2  0 byte, 1 half, 2 word
mem_sext  out  1  sign-extend load data
md_start  out  1  one-cycle issue pulse to the md unit
md_op  out  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo
md_busy  out  1  md counter nonzero
illegal  out  1  one-cycle pulse on an unrecognised instruction
state  out  3  FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4 (debug)

Behaviour:
- Reset (asynchronous, takes effect even mid-instruction): state=FETCH, md counter=0, latched control word cleared. Any pending memory request is abandoned. All outputs are 0 except imem_req, which is 1 because FETCH asserts it.
- Outputs are a function of state and the control word latched at the end of DECODE. No output depends combinationally on imem_ready or dmem_ready except ir_we and pc_we in FETCH.
- FETCH: imem_req=1 until imem_ready. In the imem_ready cycle: ir_we=1, pc_we=1, pc_src=0, next state DECODE.
- DECODE: decode instr and latch the control word.
  - Stall (stay in DECODE, all enables 0) if the instruction is mfhi/mflo/mthi/mtlo/mult/multu/div/divu and md_busy=1.
  - Unrecognised opcode or funct: illegal=1 for one cycle; treat as nop; next state FETCH.
  - Otherwise next state EXEC.
- EXEC: aluop, alusrc and extop valid. Next state depends on the instruction:
  - Branch: pc_we=br_taken, pc_src=1; next FETCH.
  - j/jal: pc_we=1, pc_src=2. jr/jalr: pc_we=1, pc_src=3.
  - mult/multu/div/divu: md_start=1; counter loads MULT_LAT or DIV_LAT at the end of this cycle; next FETCH (non-blocking).
  - mthi/mtlo: md_start=1; counter unchanged; next FETCH.
  - Loads and stores: next MEM.
  - ALU ops, jal, jalr, mfhi/mflo: next WB.
  - j, jr, nop (instr==0), sll with rd=0: next FETCH.
- MEM: dmem_req=1 held, with dmem_we, mem_size and mem_sext stable, until dmem_ready. Store then goes to FETCH; load goes to WB.
- WB: regwrite=1 for exactly one cycle, with regdst and wb_sel set; next FETCH. jal uses regdst=2, wb_sel=2. jalr uses regdst=1, wb_sel=2.
- md counter: decrements by 1 each cycle while nonzero; saturates at 0; md_busy = (cnt != 0).
- Base latency with ready asserted immediately: ALU ops and jal/jalr 4 cycles; loads 5; stores 4; branches and jumps 3. Every wait cycle on imem_ready or dmem_ready adds one cycle.

Test Plan:
- After reset, addu $3,$1,$2 with imem_ready=1: states 0,1,2,4. WB cycle: regwrite=1, regdst=1, wb_sel=0, aluop=0000. Total 4 cycles.
- lw $5,8($4) with dmem_ready arriving 3 cycles late: dmem_req high for 4 cycles, mem_size=2, extop=1. WB: wb_sel=1. Total 8 cycles.
- beq with br_taken=1: EXEC shows pc_we=1, pc_src=1. Repeat with br_taken=0: pc_we=0 in EXEC. Both return to FETCH after 3 cycles.
- div then mflo back-to-back with DIV_LAT=32: md_start=1, md_op=2. mflo holds DECODE until md_busy falls, then WB with wb_sel=3.
- Opcode 6'b111111: illegal=1 for exactly one cycle in DECODE; no regwrite, pc_we or dmem_req; next state FETCH.
- rst_n low during MEM with dmem_req=1: dmem_req drops immediately. After rst_n release: state=0, imem_req=1, md_busy=0.
